// File: rtl/laser_scan_ctrl.sv
// rtl/laser_scan_ctrl.sv - two-circle coverage search sequencer driving a shared dot evaluator
// Rasters candidates over the evaluator, keeps the best per pass and swaps which circle is fixed.
module laser_scan_ctrl #(
  parameter int NGRP     = 4,
  parameter int MAX_PASS = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [3:0]           part_cnt,
  input  logic [9:0]           part_mask,
  output logic [1:0]           grp_sel,
  output logic [3:0]           cand_x,
  output logic [3:0]           cand_y,
  output logic [NGRP*10-1:0]   fix_mask,
  output logic [3:0]           C1X,
  output logic [3:0]           C1Y,
  output logic [3:0]           C2X,
  output logic [3:0]           C2Y,
  output logic                 busy,
  output logic                 DONE
);

  localparam int NDOT = NGRP * 10;
  localparam logic [1:0] GRP_LAST  = 2'(NGRP - 1);
  localparam logic [3:0] PASS_LAST = 4'(MAX_PASS - 1);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_SWAP, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [1:0]        grp_q, grp_d;
  logic [3:0]        cx_q, cx_d, cy_q, cy_d;
  logic [5:0]        acc_q, acc_d;
  logic [NDOT-1:0]   cand_mask_q, cand_mask_d;
  logic [3:0]        best_x_q, best_x_d, best_y_q, best_y_d;
  logic [5:0]        best_cnt_q, best_cnt_d;
  logic [NDOT-1:0]   best_mask_q, best_mask_d;
  logic [3:0]        fix_x_q, fix_x_d, fix_y_q, fix_y_d;
  logic [3:0]        old_x_q, old_x_d, old_y_q, old_y_d;
  logic [NDOT-1:0]   fix_mask_q, fix_mask_d;
  logic [3:0]        pass_q, pass_d;
  logic [3:0]        c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;

  logic [5:0]        acc_sum;
  logic [5:0]        grp_base;
  logic [NDOT-1:0]   mask_new;
  logic              converged;

  always_comb begin
    state_d     = state_q;
    grp_d       = grp_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    acc_d       = acc_q;
    cand_mask_d = cand_mask_q;
    best_x_d    = best_x_q;
    best_y_d    = best_y_q;
    best_cnt_d  = best_cnt_q;
    best_mask_d = best_mask_q;
    fix_x_d     = fix_x_q;
    fix_y_d     = fix_y_q;
    old_x_d     = old_x_q;
    old_y_d     = old_y_q;
    fix_mask_d  = fix_mask_q;
    pass_d      = pass_q;
    c1x_d       = c1x_q;
    c1y_d       = c1y_q;
    c2x_d       = c2x_q;
    c2y_d       = c2y_q;

    // The group-0 cycle restarts the sum so acc never needs a separate clear cycle.
    acc_sum  = ((grp_q == 2'd0) ? 6'd0 : acc_q) + 6'(part_cnt);
    grp_base = 6'(grp_q) * 6'd10;
    mask_new = cand_mask_q;
    mask_new[grp_base +: 10] = part_mask;
    converged = (pass_q >= 4'd2) && (best_x_q == old_x_q) && (best_y_q == old_y_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_EVAL;
          grp_d       = 2'd0;
          cx_d        = 4'd0;
          cy_d        = 4'd0;
          acc_d       = 6'd0;
          best_x_d    = 4'd0;
          best_y_d    = 4'd0;
          best_cnt_d  = 6'd0;
          best_mask_d = '0;
          fix_mask_d  = '0;
          pass_d      = 4'd0;
        end
      end

      S_EVAL: begin
        acc_d       = acc_sum;
        cand_mask_d = mask_new;
        if (grp_q == GRP_LAST) begin
          if (acc_sum >= best_cnt_q) begin
            best_x_d    = cx_q;
            best_y_d    = cy_q;
            best_cnt_d  = acc_sum;
            best_mask_d = mask_new;
          end
          grp_d = 2'd0;
          cx_d  = cx_q + 4'd1;
          if (cx_q == 4'hF) begin
            cy_d = cy_q + 4'd1;
          end
          if ((cx_q == 4'hF) && (cy_q == 4'hF)) begin
            state_d = S_SWAP;
          end
        end else begin
          grp_d = grp_q + 2'd1;
        end
      end

      S_SWAP: begin
        old_x_d     = fix_x_q;
        old_y_d     = fix_y_q;
        fix_x_d     = best_x_q;
        fix_y_d     = best_y_q;
        fix_mask_d  = best_mask_q;
        c1x_d       = best_x_q;
        c1y_d       = best_y_q;
        c2x_d       = fix_x_q;
        c2y_d       = fix_y_q;
        best_x_d    = 4'd0;
        best_y_d    = 4'd0;
        best_cnt_d  = 6'd0;
        best_mask_d = '0;
        cx_d        = 4'd0;
        cy_d        = 4'd0;
        grp_d       = 2'd0;
        pass_d      = pass_q + 4'd1;
        if (converged || (pass_q == PASS_LAST)) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_EVAL;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      grp_q       <= 2'd0;
      cx_q        <= 4'd0;
      cy_q        <= 4'd0;
      acc_q       <= 6'd0;
      cand_mask_q <= '0;
      best_x_q    <= 4'd0;
      best_y_q    <= 4'd0;
      best_cnt_q  <= 6'd0;
      best_mask_q <= '0;
      fix_x_q     <= 4'd0;
      fix_y_q     <= 4'd0;
      old_x_q     <= 4'd0;
      old_y_q     <= 4'd0;
      fix_mask_q  <= '0;
      pass_q      <= 4'd0;
      c1x_q       <= 4'd0;
      c1y_q       <= 4'd0;
      c2x_q       <= 4'd0;
      c2y_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      acc_q       <= acc_d;
      cand_mask_q <= cand_mask_d;
      best_x_q    <= best_x_d;
      best_y_q    <= best_y_d;
      best_cnt_q  <= best_cnt_d;
      best_mask_q <= best_mask_d;
      fix_x_q     <= fix_x_d;
      fix_y_q     <= fix_y_d;
      old_x_q     <= old_x_d;
      old_y_q     <= old_y_d;
      fix_mask_q  <= fix_mask_d;
      pass_q      <= pass_d;
      c1x_q       <= c1x_d;
      c1y_q       <= c1y_d;
      c2x_q       <= c2x_d;
      c2y_q       <= c2y_d;
    end
  end

  // Evaluator-facing outputs read as zero whenever no candidate is being scored.
  always_comb begin
    grp_sel  = (state_q == S_EVAL) ? grp_q : 2'd0;
    cand_x   = (state_q == S_EVAL) ? cx_q  : 4'd0;
    cand_y   = (state_q == S_EVAL) ? cy_q  : 4'd0;
    fix_mask = fix_mask_q;
    C1X      = c1x_q;
    C1Y      = c1y_q;
    C2X      = c2x_q;
    C2Y      = c2y_q;
    busy     = (state_q != S_IDLE);
    DONE     = (state_q == S_FINISH);
  end

endmodule

// File: tb/tb_laser_scan_ctrl.sv
// tb/tb_laser_scan_ctrl.sv - self-checking bench for laser_scan_ctrl with a behavioural search model
// Plays the coverage evaluator (stub or real dot set) and predicts results by brute-force passes.
module tb_laser_scan_ctrl;

  localparam int MAXP     = 8;
  localparam int PASS_CYC = 1025;
  localparam int R2       = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [3:0]  part_cnt;
  logic [9:0]  part_mask;
  logic [1:0]  grp_sel;
  logic [3:0]  cand_x, cand_y;
  logic [39:0] fix_mask;
  logic [3:0]  C1X, C1Y, C2X, C2Y;
  logic        busy, DONE;

  int checks = 0;
  int failures = 0;
  int mode = 0;
  int cur_k = 0;
  int tgt;
  int dot_x[40];
  int dot_y[40];

  laser_scan_ctrl #(.NGRP(4), .MAX_PASS(MAXP)) dut (
    .CLK(CLK), .RST(RST), .start(start), .part_cnt(part_cnt), .part_mask(part_mask),
    .grp_sel(grp_sel), .cand_x(cand_x), .cand_y(cand_y), .fix_mask(fix_mask),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .busy(busy), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  function automatic bit covers(input int cx, input int cy, input int d);
    int ddx, ddy;
    ddx = dot_x[d] - cx;
    ddy = dot_y[d] - cy;
    return (ddx * ddx + ddy * ddy) <= R2;
  endfunction

  // Stub target schedule A,A,B,B,... never repeats the best of two passes earlier.
  always_comb tgt = ((((cur_k - 1) / PASS_CYC) / 2) % 2 == 1) ? 2 : 1;

  always_comb begin
    part_cnt  = 4'd0;
    part_mask = 10'd0;
    if (mode == 1) begin
      for (int i = 0; i < 10; i++) begin
        if (covers(int'(cand_x), int'(cand_y), int'(grp_sel) * 10 + i)) begin
          part_mask[i] = 1'b1;
          if (!fix_mask[int'(grp_sel) * 10 + i]) part_cnt = part_cnt + 4'd1;
        end
      end
    end else if (mode == 2) begin
      if (grp_sel == 2'd0 && cand_x == 4'(tgt) && cand_y == 4'(tgt)) part_cnt = 4'd1;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_zero(input string t);
    chk({t, "_coords"}, longint'({C1X, C1Y, C2X, C2Y, cand_x, cand_y}), 0);
    chk({t, "_grp_sel"}, longint'(grp_sel), 0);
    chk({t, "_fix_mask"}, longint'(fix_mask), 0);
    chk({t, "_busy"}, longint'(busy), 0);
    chk({t, "_done"}, longint'(DONE), 0);
  endtask

  // Brute-force search over whole passes: no groups, no cycles, just coverage counts.
  task automatic model_search(output int np, output logic [15:0] res1, output logic [15:0] res,
                              output logic [39:0] m1);
    logic [39:0] fm, m, bm;
    int fx, fy, ox, oy, bx, by, bc, cnt;
    fm = '0; fx = 0; fy = 0; ox = 0; oy = 0; np = 0; res = '0; res1 = '0; m1 = '0;
    for (int p = 0; p < MAXP; p++) begin
      bc = 0; bx = 0; by = 0; bm = '0;
      for (int y = 0; y < 16; y++) begin
        for (int x = 0; x < 16; x++) begin
          m = '0; cnt = 0;
          for (int d = 0; d < 40; d++) begin
            if (covers(x, y, d)) begin
              m[d] = 1'b1;
              if (!fm[d]) cnt++;
            end
          end
          if (cnt >= bc) begin bc = cnt; bx = x; by = y; bm = m; end
        end
      end
      res = {4'(bx), 4'(by), 4'(fx), 4'(fy)};
      if (p == 0) begin res1 = res; m1 = bm; end
      np = p + 1;
      if ((p >= 2 && bx == ox && by == oy) || (p + 1 == MAXP)) break;
      ox = fx; oy = fy; fx = bx; fy = by; fm = bm;
    end
  endtask

  task automatic run_search(input int max_cyc, input bit poke, output int done_at, output int n_done,
                            output int raster_err, output int fm_err, output int busy_err,
                            output int post_err, output logic [15:0] p1c);
    int idx, stop_at;
    done_at = -1; n_done = 0; raster_err = 0; fm_err = 0; busy_err = 0; post_err = 0;
    p1c = '0; stop_at = max_cyc;
    @(negedge CLK);
    cur_k = 0;
    start = 1'b1;
    for (int k = 1; k <= stop_at; k++) begin
      @(posedge CLK);
      #1;
      cur_k = k;
      start = poke && (k == 300 || k == 1024 || k == 1025 || k == 2100 || k == 3075 || k == 3076);
      @(negedge CLK);
      if (k <= 1024) begin
        idx = k - 1;
        if (grp_sel !== 2'(idx % 4) || cand_x !== 4'((idx / 4) % 16) || cand_y !== 4'(idx / 64))
          raster_err++;
      end
      if (k <= 1025 && fix_mask !== 40'd0) fm_err++;
      if (k == 1026) p1c = {C1X, C1Y, C2X, C2Y};
      if (DONE === 1'b1) begin
        n_done++;
        if (done_at < 0) begin done_at = k; stop_at = k + 2; end
      end
      if (done_at < 0 || k == done_at) begin
        if (busy !== 1'b1) busy_err++;
      end else if (busy !== 1'b0 || grp_sel !== 2'd0 || cand_x !== 4'd0 || cand_y !== 4'd0) begin
        post_err++;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string t, input int max_cyc, input bit poke, input int exp_done,
                           input logic [15:0] exp_p1, input logic [15:0] exp_fin);
    int done_at, n_done, raster_err, fm_err, busy_err, post_err;
    logic [15:0] p1c;
    run_search(max_cyc, poke, done_at, n_done, raster_err, fm_err, busy_err, post_err, p1c);
    chk({t, "_done_cycle"}, done_at, exp_done);
    chk({t, "_done_count"}, n_done, 1);
    chk({t, "_raster"}, raster_err, 0);
    chk({t, "_fixmask_pass1"}, fm_err, 0);
    chk({t, "_busy"}, busy_err, 0);
    chk({t, "_after_done"}, post_err, 0);
    chk({t, "_pass1_c1c2"}, longint'(p1c), longint'(exp_p1));
    chk({t, "_final_c1c2"}, longint'({C1X, C1Y, C2X, C2Y}), longint'(exp_fin));
  endtask

  initial begin
    int np, cov, dn, nd, re, fe, be, pe;
    int idle_bad;
    logic [15:0] r1, rf, pc;
    logic [39:0] m1;

    RST = 1'b1;
    start = 1'b0;

    // reset state, then idle with start low
    reset_dut();
    check_zero("rst");
    RST = 1'b0;
    idle_bad = 0;
    repeat (6) begin
      @(negedge CLK);
      if (busy !== 1'b0 || DONE !== 1'b0) idle_bad++;
    end
    chk("idle_no_start", idle_bad, 0);

    // all-zero evaluator: ties pick (15,15) every pass
    mode = 0;
    check_run("stub0", 4000, 1'b0, 1 + 3 * PASS_CYC, 16'hFF00, 16'hFFFF);

    // two random clusters with the real evaluator
    reset_dut();
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dot_x[i] = 3 + int'($urandom_range(2, 0)) - 1;
      dot_y[i] = 3 + int'($urandom_range(2, 0)) - 1;
      dot_x[i + 20] = 12 + int'($urandom_range(2, 0)) - 1;
      dot_y[i + 20] = 12 + int'($urandom_range(2, 0)) - 1;
    end
    model_search(np, r1, rf, m1);
    mode = 1;
    check_run("cluster", 9000, 1'b0, 1 + np * PASS_CYC, r1, rf);
    cov = 0;
    for (int d = 0; d < 40; d++)
      if (covers(int'(C1X), int'(C1Y), d) || covers(int'(C2X), int'(C2Y), d)) cov++;
    chk("cluster_coverage", cov, 40);

    // uniformly scattered random dots
    reset_dut();
    RST = 1'b0;
    for (int i = 0; i < 40; i++) begin
      dot_x[i] = int'($urandom_range(15, 0));
      dot_y[i] = int'($urandom_range(15, 0));
    end
    model_search(np, r1, rf, m1);
    check_run("scatter", 9000, 1'b0, 1 + np * PASS_CYC, r1, rf);

    // best never repeats two passes apart: runs to the pass cap
    reset_dut();
    RST = 1'b0;
    mode = 2;
    check_run("paritycap", 9000, 1'b0, 1 + MAXP * PASS_CYC, 16'h1100, 16'h2222);

    // reset 500 cycles into pass 2, then a clean search
    reset_dut();
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dot_x[i] = 3 + int'($urandom_range(2, 0)) - 1;
      dot_y[i] = 3 + int'($urandom_range(2, 0)) - 1;
      dot_x[i + 20] = 12 + int'($urandom_range(2, 0)) - 1;
      dot_y[i + 20] = 12 + int'($urandom_range(2, 0)) - 1;
    end
    model_search(np, r1, rf, m1);
    mode = 1;
    run_search(PASS_CYC + 500, 1'b0, dn, nd, re, fe, be, pe, pc);
    chk("midrst_prestate_fixmask", longint'(fix_mask), longint'(m1));
    chk("midrst_prestate_busy", longint'(busy), 1);
    reset_dut();
    check_zero("midrst");
    RST = 1'b0;
    mode = 0;
    check_run("after_rst", 4000, 1'b0, 1 + 3 * PASS_CYC, 16'hFF00, 16'hFFFF);

    // start pulses during EVAL, SWAP and FINISH are ignored
    reset_dut();
    RST = 1'b0;
    mode = 0;
    check_run("poke", 4000, 1'b1, 1 + 3 * PASS_CYC, 16'hFF00, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
